// File: rtl/sonic_echo_emu.sv
// Ultrasonic ranger responder: accepts a trig pulse and replies with an echo whose width encodes distance_cm.
// Latency: edge seen 3 cycles after trig moves; echo rises DELAY_US*US_DIV cycles after the fall is detected.
// Backpressure: none; triggers arriving while busy are dropped and not counted.
module sonic_echo_emu #(
  parameter int unsigned US_DIV      = 50,
  parameter int unsigned CM_US       = 58,
  parameter int unsigned MIN_TRIG_US = 10,
  parameter int unsigned DELAY_US    = 200,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 1000,
  parameter int unsigned DW          = 9
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          trig,
  input  logic [DW-1:0] distance_cm,
  output logic          echo,
  output logic          busy,
  output logic          err_short,
  output logic [15:0]   trig_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_DELAY   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  // All durations are exact cycle counts, so there is no microsecond prescaler.
  localparam logic [31:0] LP_MIN_C    = 32'(MIN_TRIG_US * US_DIV);
  localparam logic [31:0] LP_DELAY_C  = 32'(DELAY_US * US_DIV);
  localparam logic [31:0] LP_HOLD_C   = 32'(HOLDOFF_US * US_DIV);
  localparam logic [31:0] LP_TO_C     = 32'(TIMEOUT_US * US_DIV);
  localparam logic [31:0] LP_PER_CM_C = 32'(CM_US * US_DIV);
  localparam logic [31:0] LP_MAX_CM   = 32'(MAX_CM);

  logic        r_sync1, r_sync2, r_prev;
  logic        w_rise, w_fall;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_w, w_w_nxt;
  logic        r_echo, w_echo_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_err, w_err_nxt;
  logic [15:0] r_tcnt, w_tcnt_nxt;
  logic [31:0] w_dist;
  logic        w_in_range;
  logic [31:0] w_width;
  logic        w_trig_ok, w_dly_done, w_echo_done, w_hold_done;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  // Full 32-bit product; out-of-range distances (0 or beyond MAX_CM) report "no object".
  assign w_dist     = 32'(distance_cm);
  assign w_in_range = (w_dist != 32'd0) && (w_dist <= LP_MAX_CM);
  assign w_width    = w_in_range ? (w_dist * LP_PER_CM_C) : LP_TO_C;

  assign w_trig_ok   = (r_cnt >= LP_MIN_C);
  assign w_dly_done  = (r_cnt == LP_DELAY_C - 32'd1);
  assign w_echo_done = (r_cnt == r_w - 32'd1);
  assign w_hold_done = (r_cnt == LP_HOLD_C - 32'd1);

  // Two-flop synchronizer for the asynchronous trig plus a previous-value flop for edge detection.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= trig;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State and datapath registers; reset kills any echo in progress immediately.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 32'd0;
      r_w     <= 32'd0;
      r_echo  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_tcnt  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_w     <= w_w_nxt;
      r_echo  <= w_echo_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // Next-state: only a fresh rise in IDLE starts a cycle, so a trig still high after holdoff is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_rise) w_state_nxt = S_TRIG_HI;
      S_TRIG_HI: if (w_fall) w_state_nxt = w_trig_ok ? S_DELAY : S_IDLE;
      S_DELAY:   if (w_dly_done) w_state_nxt = S_ECHO;
      S_ECHO:    if (w_echo_done) w_state_nxt = S_HOLDOFF;
      S_HOLDOFF: if (w_hold_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values: counter, latched echo width, echo level, error pulse, trigger count.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_w_nxt    = r_w;
    w_echo_nxt = r_echo;
    w_err_nxt  = 1'b0;
    w_tcnt_nxt = r_tcnt;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_cnt_nxt = 32'd1;
      end
      S_TRIG_HI: begin
        if (w_fall) begin
          if (w_trig_ok) begin
            w_w_nxt    = w_width;
            w_tcnt_nxt = r_tcnt + 16'd1;
            w_cnt_nxt  = 32'd0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_DELAY: begin
        if (w_dly_done) begin
          w_cnt_nxt  = 32'd0;
          w_echo_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_ECHO: begin
        if (w_echo_done) begin
          w_cnt_nxt  = 32'd0;
          w_echo_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_HOLDOFF: begin
        w_cnt_nxt = w_hold_done ? 32'd0 : (r_cnt + 32'd1);
      end
      default: begin
        w_cnt_nxt  = 32'd0;
        w_echo_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_DELAY) || (w_state_nxt == S_ECHO) ||
                 (w_state_nxt == S_HOLDOFF);
  end

  assign echo       = r_echo;
  assign busy       = r_busy;
  assign err_short  = r_err;
  assign trig_count = r_tcnt;

endmodule

// File: tb/tb_sonic_echo_emu.sv
// Bench for sonic_echo_emu with scaled-down timing parameters.
// A timestamp-based model predicts echo/busy/err_short/trig_count every cycle.
// Directed tests pin widths, delays and counts to hand-computed literals.
module tb_sonic_echo_emu;

  localparam int P_DIV  = 2;
  localparam int P_CM   = 3;
  localparam int P_MIN  = 5;
  localparam int P_DLY  = 4;
  localparam int P_MAX  = 20;
  localparam int P_TO   = 100;
  localparam int P_HOLD = 20;
  localparam int P_DW   = 9;

  // Cycle counts implied by the parameters above.
  localparam int MIN_C  = P_MIN * P_DIV;   // 10
  localparam int DLY_C  = P_DLY * P_DIV;   // 8
  localparam int HOLD_C = P_HOLD * P_DIV;  // 40
  localparam int TO_C   = P_TO * P_DIV;    // 200

  logic            clock = 1'b0;
  logic            rst_n = 1'b1;
  logic            trig = 1'b0;
  logic [P_DW-1:0] distance_cm = '0;
  logic            echo, busy, err_short;
  logic [15:0]     trig_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sonic_echo_emu #(
    .US_DIV(P_DIV), .CM_US(P_CM), .MIN_TRIG_US(P_MIN), .DELAY_US(P_DLY),
    .MAX_CM(P_MAX), .TIMEOUT_US(P_TO), .HOLDOFF_US(P_HOLD), .DW(P_DW)
  ) dut (
    .clock(clock), .rst_n(rst_n), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .err_short(err_short), .trig_count(trig_count)
  );

  always #5 clock = ~clock;

  // Reference model: timestamps of the echo window derived from the protocol rules.
  int       m_cyc = 0;
  bit [2:0] m_h = 3'b000;       // trig samples, [0] newest
  bit       m_phase = 1'b0;     // trigger high seen, waiting for fall
  int       m_t_rise = 0;
  bit       m_busy = 1'b0;
  int       m_t_er = 0, m_t_ef = 0, m_t_idle = 0;
  int       m_err_at = -1;
  int       m_count = 0;

  always @(posedge clock or negedge rst_n) begin : model
    int  c, w, d;
    bit  rise, fall;
    if (!rst_n) begin
      m_h      <= 3'b000;
      m_phase  <= 1'b0;
      m_busy   <= 1'b0;
      m_err_at <= -1;
      m_count  <= 0;
    end else begin
      c    = m_cyc + 1;
      rise = m_h[1] && !m_h[2];
      fall = !m_h[1] && m_h[2];
      m_cyc <= c;
      m_h   <= {m_h[1:0], trig};
      if (m_busy) begin
        if (c == m_t_idle) m_busy <= 1'b0;
      end else if (m_phase) begin
        if (fall) begin
          m_phase <= 1'b0;
          if (c - m_t_rise >= MIN_C) begin
            d = int'(distance_cm);
            w = (d >= 1 && d <= P_MAX) ? d * P_CM * P_DIV : TO_C;
            m_busy   <= 1'b1;
            m_t_er   <= c + DLY_C;
            m_t_ef   <= c + DLY_C + w;
            m_t_idle <= c + DLY_C + w + HOLD_C;
            m_count  <= (m_count + 1) % 65536;
          end else begin
            m_err_at <= c;
          end
        end
      end else if (rise) begin
        m_phase  <= 1'b1;
        m_t_rise <= c;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse(input int len);
    @(posedge clock); #2 trig = 1'b1;
    repeat (len) @(posedge clock);
    #2 trig = 1'b0;
  endtask

  task automatic wait_echo(input bit lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (echo == lvl) begin ok = 1'b1; break; end
    end
  endtask

  // Watches one busy window; times are negedge indices from the call.
  task automatic measure(input int budget, output int t_b, output int t_er,
                         output int t_ef, output int t_bf);
    bit pb, pe;
    pb = busy; pe = echo;
    t_b = -1; t_er = -1; t_ef = -1; t_bf = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (busy && !pb && t_b < 0) t_b = i;
      if (echo && !pe && t_er < 0) t_er = i;
      if (!echo && pe && t_ef < 0) t_ef = i;
      if (!busy && pb && t_bf < 0) begin t_bf = i; break; end
      pb = busy; pe = echo;
    end
  endtask

  task automatic run_and_check(input string tag, input int exp_w, input int exp_cnt);
    int tb_, ter, tef, tbf;
    measure(1000, tb_, ter, tef, tbf);
    chk({tag, "_window_end"}, tbf >= 0, 1);
    chk({tag, "_delay"}, ter - tb_, DLY_C);
    chk({tag, "_width"}, tef - ter, exp_w);
    chk({tag, "_busy_len"}, tbf - tb_, DLY_C + exp_w + HOLD_C);
    chk({tag, "_count"}, trig_count, exp_cnt);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (chk_en) begin
          longint act, exp;
          bit e_echo;
          e_echo = m_busy && (m_cyc >= m_t_er) && (m_cyc < m_t_ef);
          act = {echo, busy, err_short, trig_count};
          exp = {e_echo, m_busy, (m_cyc == m_err_at), m_count[15:0]};
          chk("cycle_cmp{echo,busy,err,count}", act, exp);
        end
      end
      begin : main
        int tb_, ter, tef, tbf;
        int err_cyc, any_busy;
        bit ok;
        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_echo", echo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_short, 0);
        chk("rst_count", trig_count, 0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clock);

        // Minimum-length trigger, distance 10 -> 60 cycles
        distance_cm = 9'd10;
        pulse(MIN_C);
        run_and_check("d10", 60, 1);

        // One cycle too short -> single err_short pulse, nothing else
        repeat (5) @(posedge clock);
        pulse(MIN_C - 1);
        err_cyc = 0; any_busy = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clock);
          if (err_short) err_cyc++;
          if (busy || echo) any_busy++;
        end
        chk("short_err_cycles", err_cyc, 1);
        chk("short_no_echo", any_busy, 0);
        chk("short_count", trig_count, 1);

        // Out-of-range and boundary distances
        distance_cm = 9'd0;   pulse(12); run_and_check("d0", TO_C, 2);
        distance_cm = 9'd21;  pulse(12); run_and_check("d21", TO_C, 3);
        distance_cm = 9'd20;  pulse(12); run_and_check("d20", 120, 4);
        distance_cm = 9'd1;   pulse(12); run_and_check("d1", 6, 5);

        // Retriggers during echo / holdoff, trig high across holdoff end, distance change mid-echo
        distance_cm = 9'd5;
        pulse(MIN_C);
        fork
          measure(1000, tb_, ter, tef, tbf);
          begin
            wait_echo(1'b1, 300, ok);
            chk("retrig_echo_rise", ok, 1);
            repeat (5) @(posedge clock);
            #2 distance_cm = 9'd1;
            pulse(12);
            wait_echo(1'b0, 300, ok);
            chk("retrig_echo_fall", ok, 1);
            repeat (10) @(posedge clock);
            pulse(12);
            repeat (8) @(posedge clock);
            pulse(30);
          end
        join
        repeat (20) @(negedge clock);
        chk("retrig_width", tef - ter, 30);
        chk("retrig_busy_len", tbf - tb_, DLY_C + 30 + HOLD_C);
        chk("retrig_count", trig_count, 6);
        chk("retrig_idle", busy, 0);

        // Reset 10 cycles into an echo
        distance_cm = 9'd20;
        pulse(MIN_C);
        wait_echo(1'b1, 300, ok);
        chk("rst_mid_echo_rise", ok, 1);
        repeat (10) @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_echo", echo, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", trig_count, 0);
        repeat (3) @(posedge clock);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clock);
        distance_cm = 9'd3;
        pulse(MIN_C);
        run_and_check("after_rst", 18, 1);

        // trig stuck high: no activity until it falls
        distance_cm = 9'd7;
        @(posedge clock); #2 trig = 1'b1;
        any_busy = 0;
        for (int i = 0; i < 300; i++) begin
          @(negedge clock);
          if (busy || echo) any_busy++;
        end
        chk("stuck_quiet", any_busy, 0);
        @(posedge clock); #2 trig = 1'b0;
        run_and_check("stuck_release", 42, 2);

        repeat (5) @(posedge clock);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/sonic_echo_emu.md
Name: sonic_echo_emu

Overview:
- Emulates an HC-SR04-style ultrasonic sensor: it is the responder end of the trig/echo protocol that the `sonic` ranging driver initiates.
- Accepts a trigger pulse, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance (58 us per cm).
- Used for hardware-in-the-loop and bench verification of the ranging/counting logic, without physical sensors.

Parameters:
- US_DIV, 50, clock cycles per microsecond (50 MHz clock)
- CM_US, 58, echo microseconds per centimetre
- MIN_TRIG_US, 10, minimum trigger high time accepted
- DELAY_US, 200, trigger-fall to echo-rise delay (burst time)
- MAX_CM, 400, largest distance that returns a real echo
- TIMEOUT_US, 38000, echo width for "no object"
- HOLDOFF_US, 1000, dead time after echo falls
- DW, 9, distance input width

Ports:
- clock, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- trig, in, 1, trigger from driver (asynchronous to clock)
- distance_cm, in, DW, distance to emulate; sampled once per accepted trigger
- echo, out, 1, echo pulse to driver
- busy, out, 1, high in DELAY/ECHO/HOLDOFF
- err_short, out, 1, one-cycle pulse when a trigger is rejected as too short
- trig_count, out, 16, count of accepted triggers

Behaviour:
- Reset (async, rst_n=0):
  - echo=0, busy=0, err_short=0, trig_count=0.
  - State IDLE; all counters 0; synchronizer flops 0.
- Input sync:
  - trig passes through 2 flops; the synchronized value is sampled into a previous-value flop.
  - Rise = sync&~prev; fall = ~sync&prev.
  - Edge detection occurs 3 cycles after trig changes.
- Clock-domain arithmetic: every duration is an exact clock count X*US_DIV. No us prescaler phase error is permitted.
- Counter: one 32-bit cycle counter cnt. Echo width register W (32 bit).
- States:
  - IDLE:
    - On rise: cnt<=1, go TRIG_HI.
  - TRIG_HI:
    - cnt increments every cycle, saturating at all-ones.
    - On fall with cnt >= MIN_TRIG_US*US_DIV: latch distance_cm; W<=d*CM_US*US_DIV if 1<=d<=MAX_CM, else TIMEOUT_US*US_DIV; trig_count++ (wraps at 65535->0); cnt<=0; go DELAY.
    - On fall with cnt shorter than that: err_short=1 for exactly one cycle; go IDLE.
  - DELAY:
    - When cnt reaches DELAY_US*US_DIV-1: cnt<=0, echo<=1, go ECHO.
    - Echo rises DELAY_US*US_DIV cycles after the fall-detect cycle.
  - ECHO:
    - echo held high exactly W cycles; then echo<=0, cnt<=0, go HOLDOFF.
  - HOLDOFF:
    - After HOLDOFF_US*US_DIV cycles, go IDLE.
- busy: 1 in DELAY, ECHO and HOLDOFF, registered with the state.
- Retrigger:
  - trig edges while busy are ignored and not counted.
  - A trigger that is already high when HOLDOFF ends is not accepted. Only a fresh rise seen in IDLE starts a cycle.
- distance_cm changes after the latch have no effect on the echo in progress.
- Arithmetic: d*CM_US*US_DIV is computed at full 32-bit width (max 400*58*50=1,160,000). No truncation.
- Reset mid-echo: echo drops asynchronously to 0; no partial pulse resumes after reset.
- trig stuck high: stays in TRIG_HI with the saturating cnt; no echo is generated until a fall.

Test Plan:
- Reset then trig high 500 cycles (10 us), distance_cm=100 -> echo rises 10,000 cycles after fall detect; high exactly 290,000 cycles; trig_count=1; busy high from fall detect to end of holdoff.
- trig high 499 cycles -> err_short one-cycle pulse; echo stays 0; trig_count stays 0.
- distance_cm=0, then 401, with valid triggers -> echo width 1,900,000 cycles each time; distance_cm=400 -> width 1,160,000.
- Second trig pulse during ECHO, and one at 10 cycles into HOLDOFF -> ignored; trig_count unchanged; echo width unchanged; distance_cm change mid-echo has no effect.
- rst_n pulsed low 1000 cycles into ECHO -> echo=0 immediately; all outputs at reset values; next valid trigger behaves normally.
- Integration with `sonic` (40 ms trigger cadence) and distance_cm=37 -> driver reports distance 37 (±1 accepted) on consecutive measurements; trig_count increments once per 40 ms.
